// File: rtl/fp_unpack_stage.sv
// rtl/fp_unpack_stage.sv - two-stage IEEE-754 operand unpack with subnormal normalisation
module fp_classify #(
    parameter int exp_width  = 8,
    parameter int mant_width = 23
) (
    input  logic [exp_width+mant_width:0] f,
    output logic                          is_zero,
    output logic                          is_inf,
    output logic                          is_subn,
    output logic                          is_norm,
    output logic                          is_qnan,
    output logic                          is_snan
);
    logic [exp_width-1:0]  e_field;
    logic [mant_width-1:0] m_field;
    logic                  e_zero;
    logic                  e_ones;
    logic                  m_zero;

    assign e_field = f[exp_width+mant_width-1:mant_width];
    assign m_field = f[mant_width-1:0];
    assign e_zero  = (e_field == '0);
    assign e_ones  = &e_field;
    assign m_zero  = (m_field == '0);

    assign is_zero = e_zero & m_zero;
    assign is_subn = e_zero & ~m_zero;
    assign is_norm = ~e_zero & ~e_ones;
    assign is_inf  = e_ones & m_zero;
    // The mantissa MSB is the quiet bit; a NaN without it is signalling.
    assign is_qnan = e_ones & m_field[mant_width-1];
    assign is_snan = e_ones & ~m_zero & ~m_field[mant_width-1];
endmodule

module fp_unpack_stage #(
    parameter int num_bits   = 32,
    parameter int exp_width  = 8,
    parameter int mant_width = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [num_bits-1:0]     in_f,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic [exp_width+1:0]    out_exp,
    output logic [mant_width:0]     out_sig,
    output logic                    out_zero,
    output logic                    out_inf,
    output logic                    out_subn,
    output logic                    out_norm,
    output logic                    out_qnan,
    output logic                    out_snan
);
    localparam int EW  = exp_width + 2;
    localparam int LZW = $clog2(mant_width + 1);
    localparam logic [EW-1:0] BIAS = EW'((1 << (exp_width - 1)) - 1);

    // Class vector layout: {zero, inf, subn, norm, qnan, snan}
    localparam int C_ZERO = 5;
    localparam int C_INF  = 4;
    localparam int C_SUBN = 3;
    localparam int C_NORM = 2;

    function automatic logic [LZW-1:0] count_lz(input logic [mant_width-1:0] m);
        logic [LZW-1:0] n;
        logic           found;
        n     = LZW'(mant_width);
        found = 1'b0;
        for (int i = mant_width - 1; i >= 0; i--) begin
            if (!found && m[i]) begin
                n     = LZW'(mant_width - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic [5:0]            cls_in;
    logic [LZW-1:0]        lz_in;

    fp_classify #(
        .exp_width (exp_width),
        .mant_width(mant_width)
    ) u_classify (
        .f      (in_f),
        .is_zero(cls_in[5]),
        .is_inf (cls_in[4]),
        .is_subn(cls_in[3]),
        .is_norm(cls_in[2]),
        .is_qnan(cls_in[1]),
        .is_snan(cls_in[0])
    );

    assign lz_in = count_lz(in_f[mant_width-1:0]);

    logic                  s1_valid_q, s1_valid_d;
    logic [num_bits-1:0]   s1_f_q, s1_f_d;
    logic [5:0]            s1_cls_q, s1_cls_d;
    logic [LZW-1:0]        s1_lz_q, s1_lz_d;

    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_sign_q, s2_sign_d;
    logic [EW-1:0]         s2_exp_q, s2_exp_d;
    logic [mant_width:0]   s2_sig_q, s2_sig_d;
    logic [5:0]            s2_cls_q, s2_cls_d;

    logic                  s1_adv;
    logic                  s2_adv;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    // Data registers only load on a real transfer so idle outputs keep their last values.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_f_d     = s1_f_q;
        s1_cls_d   = s1_cls_q;
        s1_lz_d    = s1_lz_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_f_d   = in_f;
                s1_cls_d = cls_in;
                s1_lz_d  = lz_in;
            end
        end
    end

    logic [exp_width-1:0]  s1_e_field;
    logic [mant_width-1:0] s1_m_field;
    logic [LZW-1:0]        sh_amt;
    logic [mant_width:0]   subn_sig;
    logic [EW-1:0]         lz_ext;
    logic [EW-1:0]         exp_calc;
    logic [mant_width:0]   sig_calc;

    always_comb begin
        s1_e_field = s1_f_q[num_bits-2:mant_width];
        s1_m_field = s1_f_q[mant_width-1:0];
        sh_amt     = s1_lz_q + LZW'(1);
        subn_sig   = {1'b0, s1_m_field} << sh_amt;
        lz_ext     = {{(EW-LZW){1'b0}}, s1_lz_q};
        exp_calc   = BIAS + EW'(1);
        sig_calc   = {1'b1, s1_m_field};
        if (s1_cls_q[C_ZERO]) begin
            exp_calc = '0;
            sig_calc = '0;
        end else if (s1_cls_q[C_SUBN]) begin
            // 1 - bias - (lz + 1) collapses to -bias - lz
            exp_calc = EW'(0) - BIAS - lz_ext;
            sig_calc = subn_sig;
        end else if (s1_cls_q[C_NORM]) begin
            exp_calc = {2'b00, s1_e_field} - BIAS;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_exp_d   = s2_exp_q;
        s2_sig_d   = s2_sig_q;
        s2_cls_d   = s2_cls_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d = s1_f_q[num_bits-1];
                s2_exp_d  = exp_calc;
                s2_sig_d  = sig_calc;
                s2_cls_d  = s1_cls_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_f_q     <= '0;
            s1_cls_q   <= '0;
            s1_lz_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_sig_q   <= '0;
            s2_cls_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_f_q     <= s1_f_d;
            s1_cls_q   <= s1_cls_d;
            s1_lz_q    <= s1_lz_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_exp_q   <= s2_exp_d;
            s2_sig_q   <= s2_sig_d;
            s2_cls_q   <= s2_cls_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_sign  = s2_sign_q;
    assign out_exp   = s2_exp_q;
    assign out_sig   = s2_sig_q;
    assign out_zero  = s2_cls_q[C_ZERO];
    assign out_inf   = s2_cls_q[C_INF];
    assign out_subn  = s2_cls_q[C_SUBN];
    assign out_norm  = s2_cls_q[C_NORM];
    assign out_qnan  = s2_cls_q[1];
    assign out_snan  = s2_cls_q[0];
endmodule
